spi_adc_axis_capture: RTL and testbench

//  Deserialises a 1-bit serial ADC stream (source clock i_CMOS_Clk) into C_M_AXIS_TDATA_WIDTH-bit words.

---
 rtl/spi_adc_axis_capture_pkg.sv | 17 +
 rtl/spi_adc_axis_capture_axis_word_fifo.sv | 68 ++++++
 rtl/spi_adc_axis_capture.sv | 203 ++++++++++++++++++++
 tb/tb_spi_adc_axis_capture.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_axis_capture_pkg.sv
// Shared types for the serial ADC capture block: the capture/stream FSM state encoding and the
// bit positions of the o_LED status vector.
package spi_adc_axis_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRun,
    StDone
  } state_e;

  localparam int unsigned LedCapture = 0;
  localparam int unsigned LedValid   = 1;
  localparam int unsigned LedOvf     = 2;
  localparam int unsigned LedDone    = 3;

endpackage

// File: rtl/spi_adc_axis_capture_axis_word_fifo.sv
// axis_word_fifo: synchronous first-word-fall-through word FIFO (Width x Depth, Depth a power of
// two). The head word is visible on rd_data_o whenever empty_o is low; rd_en_i pops it.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_en_i, wr_data_i push a word (ignored when full)
//   rd_en_i            pop the head word (ignored when empty)
//   rd_data_o          head word
//   full_o, empty_o    status flags
//   count_o            number of stored words (0..Depth)
module spi_adc_axis_capture_axis_word_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_fire  = wr_en_i && !full_o;
    rd_fire  = rd_en_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AddrW'(1);
    // Simultaneous push and pop leaves the count unchanged.
    if (wr_fire && !rd_fire) count_d = count_q + CntW'(1);
    else if (!wr_fire && rd_fire) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a word is only observed after it has been written.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/spi_adc_axis_capture.sv
// Serial ADC capture to AXI4-Stream. A 1-bit MSB-first stream (bit clock i_CMOS_Clk, sampled as
// data) is deserialised into W-bit words, buffered in a FWFT FIFO and sent as an AXIS master in
// PKT_LEN-word packets.
// Ports:
//   M_AXIS_ACLK, M_AXIS_ARESETN   clock, asynchronous active-low reset
//   i_CMOS_Clk, i_CMOS_Data_MSB   serial ADC bit clock and data (asynchronous)
//   i_ADC_Work                    capture enable level
//   i_Mode                        0 continuous, 1 single packet (sampled when a run starts)
//   o_ADC_Done, INIT_AXI_TXN      single packet finished / one-cycle pulse on finishing
//   o_LED                         {done, overflow, tvalid, capturing}
//   M_AXIS_*                      AXI4-Stream master
module spi_adc_axis_capture
  import spi_adc_axis_capture_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 16,
  parameter int unsigned C_M_START_COUNT      = 2,
  parameter int unsigned PKT_LEN              = 8,
  parameter int unsigned FIFO_DEPTH           = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              i_CMOS_Clk,
  input  logic                              i_CMOS_Data_MSB,
  input  logic                              i_ADC_Work,
  input  logic                              i_Mode,
  output logic                              o_ADC_Done,
  output logic                              INIT_AXI_TXN,
  output logic [3:0]                        o_LED,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int unsigned W    = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned BcW  = $clog2(W);
  localparam int unsigned IdxW = $clog2(PKT_LEN);
  localparam int unsigned WcW  = $clog2(PKT_LEN + 1);
  localparam int unsigned StW  = $clog2(C_M_START_COUNT + 2);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [2:0]      clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  state_e          state_q, state_d;
  logic            mode_q, mode_d, drain_q, drain_d, pkt_done_q, pkt_done_d;
  logic            ovf_q, ovf_d, init_q, init_d;
  logic [StW-1:0]  start_cnt_q, start_cnt_d;
  logic [BcW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [W-2:0]    sr_q, sr_d;
  logic [WcW-1:0]  wr_words_q, wr_words_d;
  logic [IdxW-1:0] word_idx_q, word_idx_d;

  logic            bit_evt, din, busy, drain, capturing, word_done, fifo_wr;
  logic            fifo_full, fifo_empty, tvalid, tlast, fire;
  logic [W-1:0]    fifo_head, word;
  logic [CntW-1:0] fifo_count;

  // Stage 1/2 synchronise, stage 3 is the delayed copy used for rising-edge detection.
  assign bit_evt   = clk_sync_q[1] & ~clk_sync_q[2];
  assign din       = dat_sync_q[2];
  assign busy      = (state_q == StWait) || (state_q == StRun);
  // Draining starts the cycle work drops and persists until the FIFO is empty.
  assign drain     = busy && (drain_q || !i_ADC_Work);
  assign capturing = busy && !drain && !pkt_done_q;
  assign word      = {sr_q, din};
  assign word_done = capturing && bit_evt && (bit_cnt_q == BcW'(W - 1));
  assign fifo_wr   = word_done && !fifo_full;
  assign tvalid    = ((state_q == StRun) || drain) && !fifo_empty;
  assign fire      = tvalid && M_AXIS_TREADY;
  assign tlast     = tvalid && ((word_idx_q == IdxW'(PKT_LEN - 1)) ||
                                ((drain || pkt_done_q) && (fifo_count == CntW'(1))));

  spi_adc_axis_capture_axis_word_fifo #(
    .Width (W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (M_AXIS_ACLK),
    .rst_ni    (M_AXIS_ARESETN),
    .wr_en_i   (fifo_wr),
    .wr_data_i (word),
    .rd_en_i   (fire),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], i_CMOS_Clk};
    dat_sync_d  = {dat_sync_q[1:0], i_CMOS_Data_MSB};
    state_d     = state_q;
    mode_d      = mode_q;
    drain_d     = drain_q;
    pkt_done_d  = pkt_done_q;
    ovf_d       = ovf_q;
    init_d      = 1'b0;
    start_cnt_d = start_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    wr_words_d  = wr_words_q;
    word_idx_d  = word_idx_q;

    // Partial words are discarded whenever capture is not active.
    if (capturing) begin
      if (bit_evt) begin
        sr_d      = {sr_q[W-3:0], din};
        bit_cnt_d = word_done ? '0 : bit_cnt_q + BcW'(1);
      end
    end else begin
      sr_d      = '0;
      bit_cnt_d = '0;
    end

    if (word_done) begin
      if (fifo_full) ovf_d = 1'b1;
      if (mode_q) begin
        wr_words_d = wr_words_q + WcW'(1);
        if (wr_words_q == WcW'(PKT_LEN - 1)) pkt_done_d = 1'b1;
      end
    end

    if (fire) word_idx_d = tlast ? '0 : word_idx_q + IdxW'(1);

    case (state_q)
      StIdle: begin
        drain_d     = 1'b0;
        pkt_done_d  = 1'b0;
        wr_words_d  = '0;
        word_idx_d  = '0;
        start_cnt_d = '0;
        if (i_ADC_Work && !o_ADC_Done) begin
          state_d = StWait;
          mode_d  = i_Mode;
        end
      end
      StWait, StRun: begin
        if (drain) begin
          drain_d = 1'b1;
          if (fifo_empty) state_d = StIdle;
        end else if (state_q == StWait) begin
          start_cnt_d = start_cnt_q + StW'(1);
          if (32'(start_cnt_q) + 32'd1 >= C_M_START_COUNT) state_d = StRun;
        end else if (mode_q && fire && tlast) begin
          state_d = StDone;
          init_d  = 1'b1;
        end
      end
      StDone: begin
        if (!i_ADC_Work) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      clk_sync_q  <= '0;
      dat_sync_q  <= '0;
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      drain_q     <= 1'b0;
      pkt_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
      init_q      <= 1'b0;
      start_cnt_q <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      wr_words_q  <= '0;
      word_idx_q  <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      drain_q     <= drain_d;
      pkt_done_q  <= pkt_done_d;
      ovf_q       <= ovf_d;
      init_q      <= init_d;
      start_cnt_q <= start_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      wr_words_q  <= wr_words_d;
      word_idx_q  <= word_idx_d;
    end
  end

  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tvalid ? fifo_head : '0;
  assign M_AXIS_TLAST  = tlast;
  assign M_AXIS_TSTRB  = '1;
  assign o_ADC_Done    = (state_q == StDone);
  assign INIT_AXI_TXN  = init_q;

  always_comb begin
    o_LED             = '0;
    o_LED[LedCapture] = capturing;
    o_LED[LedValid]   = tvalid;
    o_LED[LedOvf]     = ovf_q;
    o_LED[LedDone]    = o_ADC_Done;
  end

endmodule

// File: tb/tb_spi_adc_axis_capture.sv
// Self-checking bench for spi_adc_axis_capture (W=16, PKT_LEN=8, FIFO_DEPTH=16).
module tb_spi_adc_axis_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_clk = 1'b0;
  logic        cmos_data = 1'b0;
  logic        work = 1'b0;
  logic        mode = 1'b0;
  logic        tready;
  logic        done, init, tvalid, tlast;
  logic [3:0]  led;
  logic [15:0] tdata;
  logic [1:0]  tstrb;

  always #5 clk = ~clk;

  spi_adc_axis_capture dut (
    .M_AXIS_ACLK     (clk),
    .M_AXIS_ARESETN  (rst_n),
    .i_CMOS_Clk      (cmos_clk),
    .i_CMOS_Data_MSB (cmos_data),
    .i_ADC_Work      (work),
    .i_Mode          (mode),
    .o_ADC_Done      (done),
    .INIT_AXI_TXN    (init),
    .o_LED           (led),
    .M_AXIS_TVALID   (tvalid),
    .M_AXIS_TDATA    (tdata),
    .M_AXIS_TSTRB    (tstrb),
    .M_AXIS_TLAST    (tlast),
    .M_AXIS_TREADY   (tready)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_data;
    logic        exp_last;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } xfer_t;

  vec_t        vecs[8];
  xfer_t       got[$];
  int          checks = 0;
  int          errors = 0;
  int          init_pulses = 0;
  int          rdy_mode = 0;  // 0 low, 1 high, 2 high one cycle in three
  int          rdy_phase = 0;
  logic        stall_chk = 1'b0;
  logic        stall_pend = 1'b0;
  logic [15:0] held_d;
  logic        held_l;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // TREADY changes just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) begin
      tready    = (rdy_phase == 0);
      rdy_phase = (rdy_phase + 1) % 3;
    end else begin
      tready = (rdy_mode == 1);
    end
  end

  // Outputs sampled on the falling edge; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (stall_chk && stall_pend) begin
      check("stall_tvalid", 32'(tvalid), 32'd1);
      check("stall_tdata", 32'(tdata), 32'(held_d));
      check("stall_tlast", 32'(tlast), 32'(held_l));
    end
    stall_pend = tvalid && !tready;
    held_d     = tdata;
    held_l     = tlast;
    if (tvalid && tready) got.push_back('{d: tdata, l: tlast});
    if (init) init_pulses++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    cmos_data = b;
    cmos_clk  = 1'b0;
    cycles(3);
    cmos_clk  = 1'b1;
    cycles(3);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int b = 15; b >= 0; b--) send_bit(w[b]);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      cycles(1);
      k++;
    end
  endtask

  task automatic run_mode1(input string tag);
    int k = 0;
    got.delete();
    init_pulses = 0;
    mode = 1'b1;
    work = 1'b1;
    for (int i = 0; i < 8; i++) send_word(vecs[i].din);
    while (!done && k < 300) begin
      cycles(1);
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_led3"}, 32'(led[3]), 32'd1);
    check({tag, "_count"}, got.size(), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check($sformatf("%s_tdata%0d", tag, i), 32'(got[i].d), 32'(vecs[i].exp_data));
      check($sformatf("%s_tlast%0d", tag, i), 32'(got[i].l), 32'(vecs[i].exp_last));
    end
    cycles(5);
    check({tag, "_init_pulses"}, init_pulses, 32'd1);
    work = 1'b0;
    cycles(5);
    check({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 16'hA5C3, exp_data: 16'hA5C3, exp_last: 1'b0};
    vecs[1] = '{din: 16'h0001, exp_data: 16'h0001, exp_last: 1'b0};
    vecs[2] = '{din: 16'h0002, exp_data: 16'h0002, exp_last: 1'b0};
    vecs[3] = '{din: 16'h0003, exp_data: 16'h0003, exp_last: 1'b0};
    vecs[4] = '{din: 16'h0004, exp_data: 16'h0004, exp_last: 1'b0};
    vecs[5] = '{din: 16'h0005, exp_data: 16'h0005, exp_last: 1'b0};
    vecs[6] = '{din: 16'h0006, exp_data: 16'h0006, exp_last: 1'b0};
    vecs[7] = '{din: 16'h0007, exp_data: 16'h0007, exp_last: 1'b1};

    // Reset
    cycles(3);
    check("rst_hold_tvalid", 32'(tvalid), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tstrb", 32'(tstrb), 32'h3);
    check("rst_done", 32'(done), 32'd0);
    check("rst_init", 32'(init), 32'd0);
    check("rst_led", 32'(led), 32'd0);

    // Single packet, sink always ready
    rdy_mode = 1;
    run_mode1("m1");

    // Single packet, sink ready one cycle in three
    rdy_mode  = 2;
    stall_chk = 1'b1;
    run_mode1("m1_stall");
    stall_chk = 1'b0;

    // Work dropped after 3 words + 5 bits
    rdy_mode = 0;
    got.delete();
    mode = 1'b0;
    work = 1'b1;
    send_word(16'h0F0F);
    send_word(16'hF00D);
    send_word(16'h1357);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    work = 1'b0;
    cycles(3);
    check("drop_tvalid", 32'(tvalid), 32'd1);
    rdy_mode = 1;
    wait_xfers(3, 50);
    cycles(5);
    check("drop_count", got.size(), 32'd3);
    if (got.size() >= 3) begin
      check("drop_tdata0", 32'(got[0].d), 32'h0F0F);
      check("drop_tdata1", 32'(got[1].d), 32'hF00D);
      check("drop_tdata2", 32'(got[2].d), 32'h1357);
      check("drop_tlast0", 32'(got[0].l), 32'd0);
      check("drop_tlast1", 32'(got[1].l), 32'd0);
      check("drop_tlast2", 32'(got[2].l), 32'd1);
    end
    check("drop_idle_led", 32'(led), 32'd0);
    got.delete();
    work = 1'b1;
    send_word(16'h1234);
    wait_xfers(1, 50);
    check("restart_count", got.size(), 32'd1);
    if (got.size() >= 1) begin
      check("restart_tdata", 32'(got[0].d), 32'h1234);
      check("restart_tlast", 32'(got[0].l), 32'd0);
    end
    work = 1'b0;
    cycles(5);

    // Continuous mode overflow
    rdy_mode = 0;
    got.delete();
    mode = 1'b0;
    work = 1'b1;
    for (int i = 1; i <= 20; i++) send_word(16'(i));
    cycles(5);
    check("ovf_led2", 32'(led[2]), 32'd1);
    check("ovf_tvalid", 32'(tvalid), 32'd1);
    rdy_mode = 1;
    wait_xfers(16, 100);
    cycles(20);
    check("ovf_count", got.size(), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      check($sformatf("ovf_tdata%0d", i), 32'(got[i].d), 32'(i + 1));
      check($sformatf("ovf_tlast%0d", i), 32'(got[i].l), 32'((i % 8) == 7));
    end
    work = 1'b0;
    cycles(5);
    check("ovf_sticky_led", 32'(led), 32'h4);

    // Reset mid-packet
    rdy_mode = 0;
    got.delete();
    mode = 1'b0;
    work = 1'b1;
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    cycles(3);
    check("mid_tvalid", 32'(tvalid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(tvalid), 32'd0);
    check("mid_rst_tdata", 32'(tdata), 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    work      = 1'b0;
    cmos_clk  = 1'b0;
    cmos_data = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    rdy_mode = 1;
    run_mode1("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
